// File: rtl/ysyx_22040729_alu_seq_divider_pkg.sv
// Shared types and constants for the sequential radix-2 divider.
package ysyx_22040729_alu_seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam int WORD_W = 32;

  // Wide enough to hold the iteration count N itself, not just N-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ysyx_22040729_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract, select.
module ysyx_22040729_div_step
  import ysyx_22040729_alu_seq_divider_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] partial;
  logic           fits;

  always_comb begin
    // The shifted remainder needs one extra bit before the trial subtract.
    partial = {rem_i, quo_i[WIDTH-1]};
    fits    = partial >= {1'b0, divisor_i};
    rem_o   = fits ? (partial[WIDTH-1:0] - divisor_i) : partial[WIDTH-1:0];
    quo_o   = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/ysyx_22040729_alu_seq_divider.sv
// Multi-cycle radix-2 restoring divider with RISC-V signed/unsigned/word semantics.
module ysyx_22040729_alu_seq_divider
  import ysyx_22040729_alu_seq_divider_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic             in_word,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder
);

  localparam int               CNT_W        = cnt_width(WIDTH);
  localparam int               WORD_SHIFT   = WIDTH - WORD_W;
  localparam logic [WIDTH-1:0] FULL_MIN     = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] WORD_MIN_EXT = ~WIDTH'(32'h7FFF_FFFF);

  function automatic logic [WIDTH-1:0] sext_word(input logic [WIDTH-1:0] x);
    return WIDTH'(signed'(x[WORD_W-1:0]));
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] res_quo_q, res_quo_d, res_rem_q, res_rem_d;
  logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, word_q, word_d;

  logic [WIDTH-1:0] a_ext, b_ext, a_mag, b_mag;
  logic             a_neg, b_neg, div_zero, overflow, accept;
  logic [WIDTH-1:0] step_rem, step_quo, quo_fix, rem_fix;
  logic [CNT_W-1:0] n_target;

  ysyx_22040729_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  // Operand preparation and special-case detection on the live inputs.
  always_comb begin
    a_ext    = in_word ? (in_signed ? sext_word(in_dividend) : WIDTH'(in_dividend[WORD_W-1:0]))
                       : in_dividend;
    b_ext    = in_word ? (in_signed ? sext_word(in_divisor) : WIDTH'(in_divisor[WORD_W-1:0]))
                       : in_divisor;
    a_neg    = in_signed & a_ext[WIDTH-1];
    b_neg    = in_signed & b_ext[WIDTH-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    overflow = in_signed & (a_ext == (in_word ? WORD_MIN_EXT : FULL_MIN)) & (&b_ext);
  end

  // Word-mode results are always sign-extended from bit 31, even for divuw/remuw.
  always_comb begin
    quo_fix  = neg_quo_q ? -quo_q : quo_q;
    rem_fix  = neg_rem_q ? -rem_q : rem_q;
    n_target = word_q ? CNT_W'(WORD_W) : CNT_W'(WIDTH);
  end

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q == DONE);
  assign out_quotient  = res_quo_q;
  assign out_remainder = res_rem_q;
  assign accept        = in_valid & in_ready & ~flush;

  // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    res_quo_d = res_quo_q;
    res_rem_d = res_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    word_d    = word_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d     = '0;
          word_d    = in_word;
          neg_quo_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (div_zero) begin
            res_quo_d = '1;
            res_rem_d = in_word ? sext_word(in_dividend) : in_dividend;
            state_d   = DONE;
          end else if (overflow) begin
            res_quo_d = a_ext;
            res_rem_d = '0;
            state_d   = DONE;
          end else begin
            rem_d   = '0;
            // Word operands sit in the upper half so they shift out first.
            quo_d   = in_word ? (a_mag << WORD_SHIFT) : a_mag;
            dvs_d   = b_mag;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == n_target) begin
          res_quo_d = word_q ? sext_word(quo_fix) : quo_fix;
          res_rem_d = word_q ? sext_word(rem_fix) : rem_fix;
          state_d   = DONE;
        end else begin
          rem_d = step_rem;
          quo_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      res_quo_q <= '0;
      res_rem_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      word_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      res_quo_q <= res_quo_d;
      res_rem_q <= res_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      word_q    <= word_d;
    end
  end

endmodule

// File: tb/tb_ysyx_22040729_alu_seq_divider.sv
// Self-checking bench: directed RISC-V division cases plus randomized traffic against a scoreboard.
module tb_ysyx_22040729_alu_seq_divider;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic         in_signed;
  logic         in_word;
  logic [W-1:0] in_dividend;
  logic [W-1:0] in_divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    logic [63:0] q;
    logic [63:0] r;
    int          due;
  } exp_t;

  exp_t sb[$];

  ysyx_22040729_alu_seq_divider #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_signed    (in_signed),
    .in_word      (in_word),
    .in_dividend  (in_dividend),
    .in_divisor   (in_divisor),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_quotient (out_quotient),
    .out_remainder(out_remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RISC-V division semantics straight from the operator definitions.
  function automatic exp_t model(input bit s, input bit w, input logic [63:0] a,
                                 input logic [63:0] b, input int now);
    exp_t        e;
    logic [31:0] a32, b32, q32, r32;
    bit          special;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      special = (b32 == 0) || (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF);
      if (b32 == 0) begin
        q32 = '1; r32 = a32;
      end else if (special) begin
        q32 = a32; r32 = 0;
      end else if (s) begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      e.q = {{32{q32[31]}}, q32};
      e.r = {{32{r32[31]}}, r32};
      e.due = now + 1 + (special ? 0 : 33);
    end else begin
      special = (b == 0) || (s && a == 64'h8000_0000_0000_0000 && b == '1);
      if (b == 0) begin
        e.q = '1; e.r = a;
      end else if (special) begin
        e.q = a; e.r = 0;
      end else if (s) begin
        e.q = $signed(a) / $signed(b); e.r = $signed(a) % $signed(b);
      end else begin
        e.q = a / b; e.r = a % b;
      end
      e.due = now + 1 + (special ? 0 : 65);
    end
    return e;
  endfunction

  // Per-cycle compare against the scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    bit   exp_ov;
    cyc++;
    if (rst) begin
      sb.delete();
    end else begin
      check("in_ready", {63'd0, in_ready}, {63'd0, sb.size() == 0});
      exp_ov = (sb.size() != 0) && (cyc >= sb[0].due);
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
      if (out_valid && sb.size() != 0) begin
        check("quotient", out_quotient, sb[0].q);
        check("remainder", out_remainder, sb[0].r);
      end
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
        if (in_valid && in_ready) begin
          e = model(in_signed, in_word, in_dividend, in_divisor, cyc);
          sb.push_back(e);
        end
      end
    end
  end

  // Called #1 after a rising edge with the DUT idle; returns #1 after the accept edge.
  task automatic issue(input bit s, input bit w, input logic [63:0] a, input logic [63:0] b);
    in_valid    = 1'b1;
    in_signed   = s;
    in_word     = w;
    in_dividend = a;
    in_divisor  = b;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    in_signed   = $urandom_range(0, 1);
    in_word     = $urandom_range(0, 1);
    in_dividend = {$urandom, $urandom};
    in_divisor  = {$urandom, $urandom};
  endtask

  // Directed op with literal expectations; latency counts edges after the accept edge.
  task automatic run_dir(input string name, input bit s, input bit w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] eq, input logic [63:0] er,
                         input int elat);
    int lat;
    bit seen;
    issue(s, w, a, b);
    lat  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      lat++;
    end
    check({name, "_seen"}, {63'd0, seen}, 64'd1);
    check({name, "_lat"}, 64'(lat), 64'(elat));
    check({name, "_q"}, out_quotient, eq);
    check({name, "_r"}, out_remainder, er);
    @(posedge clk);
    @(negedge clk);
    check({name, "_ready_after"}, {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 15));
      4:       return {32'hDEAD_BEEF, 32'h8000_0000};
      5:       return {$urandom, 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] hq, hr;
    bit          timed_out;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0; in_word = 1'b0;
    in_dividend = '0; in_divisor = '0; out_ready = 1'b1;
    #2;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_q", out_quotient, 64'd0);
    check("rst_r", out_remainder, 64'd0);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    run_dir("udiv_100_7", 0, 0, 64'd100, 64'd7, 64'd14, 64'd2, 65);
    run_dir("sdiv_m7_2", 1, 0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
            64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_dir("sdiv_7_m2", 1, 0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
            64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 65);
    run_dir("dz_signed", 1, 0, 64'h1234, 64'd0, '1, 64'h1234, 0);
    run_dir("dz_unsigned", 0, 0, 64'h1234, 64'd0, '1, 64'h1234, 0);
    run_dir("ovf_full", 1, 0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 64'd0, 0);
    run_dir("ovf_word", 1, 1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 64'd0, 0);
    run_dir("divuw_fffe_2", 0, 1, 64'hFFFF_FFFE, 64'd2, 64'h7FFF_FFFF, 64'd0, 33);
    run_dir("divuw_ffff_1", 0, 1, 64'hFFFF_FFFF, 64'd1, '1, 64'd0, 33);
    run_dir("divuw_hi_a", 0, 1, 64'hDEAD_BEEF_FFFF_FFFE, 64'hDEAD_BEEF_0000_0002,
            64'h7FFF_FFFF, 64'd0, 33);
    run_dir("divuw_hi_b", 0, 1, 64'hDEAD_BEEF_FFFF_FFFF, 64'hDEAD_BEEF_0000_0001, '1, 64'd0, 33);

    // Backpressure: result must hold while out_ready stays low.
    out_ready = 1'b0;
    issue(0, 0, 64'd1000, 64'd33);
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        timed_out = 1'b0;
        break;
      end
    end
    check("bp_timeout", {63'd0, timed_out}, 64'd0);
    hq = out_quotient;
    hr = out_remainder;
    check("bp_q", hq, 64'd30);
    check("bp_r", hr, 64'd10);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
      check("bp_hold_ready", {63'd0, in_ready}, 64'd0);
      check("bp_hold_q", out_quotient, hq);
      check("bp_hold_r", out_remainder, hr);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Flush at BUSY cycle 10.
    issue(1, 0, 64'd123456789, 64'd321);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      check("flush_valid", {63'd0, out_valid}, 64'd0);
    end
    check("flush_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset mid-BUSY.
    issue(0, 0, 64'hFFFF_0000_1234_5678, 64'd77);
    repeat (20) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_ready", {63'd0, in_ready}, 64'd1);
    check("arst_q", out_quotient, 64'd0);
    check("arst_r", out_remainder, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure; the compare process checks every cycle.
    for (int n = 0; n < 250; n++) begin
      issue($urandom_range(0, 1), $urandom_range(0, 1), rand_operand(), rand_operand());
      timed_out = 1'b1;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        if (in_ready && !out_valid) begin
          timed_out = 1'b0;
          break;
        end
        @(posedge clk);
        #1 out_ready = ($urandom_range(0, 3) != 0);
      end
      check("rand_drain", {63'd0, timed_out}, 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ysyx_22040729_alu_seq_divider.md
Name: ysyx_22040729_alu_seq_divider

Overview:
- Multi-cycle iterative divider for the EXU's M-extension path; replaces the single-cycle combinational array divider for timing.
- Radix-2 restoring algorithm, one quotient bit per cycle.
- Supports signed/unsigned and RV64 word (32-bit) mode, with RISC-V divide-by-zero and overflow semantics.
- Valid/ready handshake on input and output, plus a pipeline flush.

Parameters:
- WIDTH, 64, datapath width in bits; must be >= 32. At 32, word mode is identical to full mode.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous abort of the current operation
- in_valid  in  1  operands valid
- in_ready  out  1  divider can accept; high only in IDLE
- in_signed  in  1  1 = signed (div/rem), 0 = unsigned (divu/remu)
- in_word  in  1  1 = operate on low 32 bits (divw family)
- in_dividend  in  WIDTH  dividend
- in_divisor  in  WIDTH  divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_quotient  out  WIDTH  quotient
- out_remainder  out  WIDTH  remainder

Behaviour:
- Reset (async, rst=1): state IDLE, in_ready=1, out_valid=0, out_quotient=0, out_remainder=0, counter=0.
- States and transitions:
  - IDLE -> BUSY on accept (in_valid & in_ready at a rising edge).
  - IDLE -> DONE on accept when the operation is a special case.
  - BUSY -> DONE when the counter reaches N.
  - DONE -> IDLE on out_valid & out_ready.
- Operand prep at accept:
  - Word mode: take bits [31:0] of each operand, sign-extended if in_signed, else zero-extended, to internal width.
  - Signed: divide the magnitudes; record neg_q = sign(a) XOR sign(b) and neg_r = sign(a).
  - Unsigned: neg_q = neg_r = 0.
- Iteration count N = in_word ? 32 : WIDTH.
  - Each BUSY cycle: shift the {rem,quo} pair left by 1, trial-subtract the divisor from the upper half, set the quotient LSB if non-negative.
  - Counter width: $clog2(WIDTH+1).
- Latency: accept at edge 0; BUSY for edges 1..N; out_valid high after edge N+1.
  - 65 cycles for WIDTH=64 full mode; 33 cycles in word mode.
- Post-fix: negate the quotient if neg_q; negate the remainder if neg_r.
- Word-mode result width: the 32-bit result is sign-extended to WIDTH for both signed and unsigned (RV64 divuw/remuw semantics).
- Special cases are decided at accept; they skip BUSY and give out_valid after edge 1.
  - Divisor == 0: quotient = all ones; remainder = dividend (word mode: sign-extended dividend[31:0]).
  - Signed overflow (dividend = most negative value of the active width, divisor = -1): quotient = dividend (sign-extended in word mode); remainder = 0.
- Output hold: while out_valid & !out_ready, out_quotient and out_remainder are held stable.
- Handoff: the out_valid & out_ready edge returns the block to IDLE; in_ready rises the following cycle. There is no same-cycle re-accept.
- Flush:
  - Highest priority among synchronous controls. At the next edge, any state -> IDLE and out_valid=0.
  - in_valid is ignored in a flush cycle.
  - The result registers may hold stale data.
- Reset mid-operation aborts immediately; no output is produced.
- Operands are registered at accept; input changes after accept have no effect.

Decomposition:
- Shared package holds:
  - state enum {IDLE, BUSY, DONE};
  - localparam WORD_W = 32;
  - the counter-width function.
- One sub-module: ysyx_22040729_div_step, a combinational single-iteration shift/trial-subtract/select, parametrised by WIDTH.
- Sign pre/post-fix, special-case detection and the FSM stay in the top module.

Test Plan:
- Unsigned full mode (WIDTH=64), 100 / 7, out_ready=1 -> q=14, r=2; out_valid exactly 65 cycles after accept, for one cycle; in_ready high the cycle after.
- Signed full mode, -7 / 2 -> q=0xFFFF_FFFF_FFFF_FFFD (-3), r=0xFFFF_FFFF_FFFF_FFFF (-1); 7 / -2 -> q=-3, r=1.
- Divide by zero, 0x1234 / 0 (signed and unsigned) -> q=0xFFFF_FFFF_FFFF_FFFF, r=0x1234; out_valid 1 cycle after accept.
- Overflow, both modes:
  - Full: 0x8000_0000_0000_0000 / -1 signed -> q=0x8000_0000_0000_0000, r=0.
  - Word: divw 0x8000_0000 / 0xFFFF_FFFF -> q=0xFFFF_FFFF_8000_0000, r=0.
- Word unsigned, latency 33 cycles:
  - divuw 0x0000_0000_FFFF_FFFE / 2 -> q=0x0000_0000_7FFF_FFFF, r=0.
  - divuw 0xFFFF_FFFF / 1 -> q=0xFFFF_FFFF_FFFF_FFFF.
  - Upper operand bits set to 0xDEAD_BEEF give identical results.
- Backpressure, flush and reset:
  - out_ready held low 5 cycles after out_valid -> outputs stable; in_ready=0 throughout.
  - flush at BUSY cycle 10 -> IDLE next edge, out_valid never asserted, in_ready=1.
  - rst pulsed mid-BUSY -> all outputs return to reset values immediately.
